// File: rtl/uart_alu_pkg.sv
// Shared definitions for the uart_alu packet path: opcodes, header size,
// receive-framer FSM states and opcode classification.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;
  localparam logic [7:0] OP_DIV  = 8'hD0;

  typedef enum logic [7:0] {
    OPE_ECHO = OP_ECHO,
    OPE_ADD  = OP_ADD,
    OPE_MUL  = OP_MUL,
    OPE_DIV  = OP_DIV
  } op_e;

  // Header is [op][rsvd][len_lo][len_hi]; len counts these bytes too.
  localparam logic [15:0] HdrBytes = 16'd4;

  typedef enum logic [2:0] {
    S_OP,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_DRAIN
  } state_e;

  // Opcodes whose payload is a sequence of 32-bit little-endian operands.
  function automatic logic is_arith(logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/uart_alu_pkt_obuf.sv
// One-entry valid/ready output register for operand beats.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              capture word_in/first_in/last_in as a new beat
//   word_in, first_in, last_in  beat payload and packet-position flags
//   op_load, op_in    update the packet opcode register
//   ready             downstream accepts the held beat
//   valid, word, first, last, op  registered outputs
// The caller only asserts load when the slot is free or draining this cycle,
// so a beat is never overwritten before it transfers.
module uart_alu_pkt_obuf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        first_in,
  input  logic        last_in,
  input  logic        op_load,
  input  logic [7:0]  op_in,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] word,
  output logic        first,
  output logic        last,
  output logic [7:0]  op
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= 32'h0;
      first <= 1'b0;
      last  <= 1'b0;
      op    <= 8'h00;
    end else begin
      if (load) begin
        valid <= 1'b1;
        word  <= word_in;
        first <= first_in;
        last  <= last_in;
      end else if (ready) begin
        // word is left as-is; only the qualifiers drop after transfer
        valid <= 1'b0;
        first <= 1'b0;
        last  <= 1'b0;
      end
      if (op_load) op <= op_in;
    end
  end

endmodule

// File: rtl/uart_alu_pkt_rx.sv
// Packet framer between the UART receiver and the ALU. Parses
// [op][rsvd][len_lo][len_hi][payload] and emits payload as operand beats.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o  byte stream in
//   op_o                          opcode of the current packet
//   word_o/word_valid_o/word_ready_i  operand beat out
//   first_o, last_o               first / final beat of the packet
//   err_o                         one-cycle malformed-packet pulse
// Parameter MaxLen: largest accepted packet length (header included).
// Macro UART_ALU_PKT_CHECK_EN: enables header checks, err_o and draining of
// bad packets. Without it unknown opcodes frame as arithmetic and a trailing
// partial word is dropped.
module uart_alu_pkt_rx
  import uart_alu_pkg::*;
#(
  parameter logic [15:0] MaxLen = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  op_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        first_o,
  output logic        last_o,
  output logic        err_o
);

  state_e      state;
  logic [7:0]  len_lo;
  logic [15:0] cnt;        // payload bytes still to come
  logic [23:0] sreg;       // first three bytes of the word being assembled
  logic [1:0]  idx;        // byte position within the current word
  logic        first_pend; // next beat is the first of the packet
  logic        err;

  logic        byte_fire, can_load, echo;
  logic [15:0] len, pay_len, cnt_nxt;
  logic        beat_load, beat_last, hdr_err;
  logic [31:0] beat_word;

  // The slot is usable if empty or being emptied this cycle. S_OP also waits
  // on it so op_o cannot change under the previous packet's last beat.
  assign can_load   = !word_valid_o || word_ready_i;
  assign rx_ready_o = (state == S_PAYLOAD || state == S_OP) ? can_load : 1'b1;
  assign byte_fire  = rx_valid_i && rx_ready_o;

  assign len     = {rx_data_i, len_lo};
  assign pay_len = len - HdrBytes;
  assign cnt_nxt = cnt - 16'd1;
  assign echo    = (op_o == OP_ECHO);
  assign err_o   = err;

`ifdef UART_ALU_PKT_CHECK_EN
  always_comb begin
    hdr_err = 1'b0;
    if (!(is_arith(op_o) || echo)) hdr_err = 1'b1;
    if (len < HdrBytes)            hdr_err = 1'b1;
    if (len > MaxLen)              hdr_err = 1'b1;
    if (is_arith(op_o) && (pay_len[1:0] != 2'd0 || len == HdrBytes)) hdr_err = 1'b1;
  end
`else
  logic [15:0] unused_maxlen;
  assign unused_maxlen = MaxLen;
  assign hdr_err       = 1'b0;
`endif

  // Beat formation for the byte accepted this cycle.
  always_comb begin
    beat_load = 1'b0;
    beat_last = 1'b0;
    beat_word = {rx_data_i, sreg};
    if (byte_fire && state == S_PAYLOAD) begin
      if (echo) begin
        beat_load = 1'b1;
        beat_word = {24'h0, rx_data_i};
        beat_last = (cnt_nxt == 16'd0);
      end else if (idx == 2'd3) begin
        beat_load = 1'b1;
        // fewer than 4 bytes left means no further complete word
        beat_last = (cnt_nxt < 16'd4);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_OP;
      len_lo     <= 8'h00;
      cnt        <= 16'h0;
      sreg       <= 24'h0;
      idx        <= 2'd0;
      first_pend <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= byte_fire && (state == S_LEN_HI) && hdr_err;
      if (byte_fire) begin
        case (state)
          S_OP:     state <= S_RSVD;
          S_RSVD:   state <= S_LEN_LO;
          S_LEN_LO: begin
            len_lo <= rx_data_i;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            cnt        <= (len > HdrBytes) ? pay_len : 16'h0;
            idx        <= 2'd0;
            sreg       <= 24'h0;
            first_pend <= !hdr_err;
            if (len > HdrBytes) state <= hdr_err ? S_DRAIN : S_PAYLOAD;
            else                state <= S_OP;
          end
          S_PAYLOAD: begin
            cnt  <= cnt_nxt;
            sreg <= {rx_data_i, sreg[23:8]};
            idx  <= idx + 2'd1;
            if (beat_load) first_pend <= 1'b0;
            if (cnt_nxt == 16'd0) begin
              state <= S_OP;
              sreg  <= 24'h0;
              idx   <= 2'd0;
            end
          end
          S_DRAIN: begin
            cnt <= cnt_nxt;
            if (cnt_nxt == 16'd0) state <= S_OP;
          end
          default: state <= S_OP;
        endcase
      end
    end
  end

  uart_alu_pkt_obuf u_obuf (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .load     (beat_load),
    .word_in  (beat_word),
    .first_in (first_pend),
    .last_in  (beat_last),
    .op_load  (byte_fire && state == S_OP),
    .op_in    (rx_data_i),
    .ready    (word_ready_i),
    .valid    (word_valid_o),
    .word     (word_o),
    .first    (first_o),
    .last     (last_o),
    .op       (op_o)
  );

endmodule

// File: tb/tb_uart_alu_pkt_rx.sv
// Self-checking bench for uart_alu_pkt_rx: packet table with hand-computed
// beats, scoreboard queue checked by a negedge monitor, plus hand sequences
// for backpressure, mid-packet reset and back-to-back streaming.
module tb_uart_alu_pkt_rx;

`ifdef UART_ALU_PKT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  op_o;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b1;
  logic        first_o, last_o, err_o;

  uart_alu_pkt_rx dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .op_o         (op_o),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .first_o      (first_o),
    .last_o       (last_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int               n;
    logic [127:0]     raw;   // right-aligned, first byte most significant
    int               nexp;
    logic [3:0][31:0] w;     // w[0] is the first expected beat
    logic             err;
  } vec_t;

  typedef struct packed {
    logic [31:0] w;
    logic        first;
    logic        last;
    logic [7:0]  op;
  } beat_t;

  beat_t exp_q[$];
  vec_t  tbl[11];
  int    tests = 0, fails = 0;
  int    err_seen = 0, stall_cnt = 0, cyc = 0;
  logic  mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int n, logic [127:0] raw, int nexp, logic [3:0][31:0] w, logic err);
    vec_t v;
    v.n = n; v.raw = raw; v.nexp = nexp; v.w = w; v.err = err;
    return v;
  endfunction

  // Monitor: scoreboard pops on transfer, stability while stalled, err count.
  initial begin
    logic        hold_prev = 1'b0;
    logic [31:0] prev_w = 32'h0;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (!rst_ni || !mon_en) begin
        hold_prev = 1'b0;
      end else begin
        if (err_o) err_seen++;
        if (hold_prev) chk("held_beat", {31'h0, word_valid_o, word_o}, {31'h0, 1'b1, prev_w});
        if (word_valid_o && word_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {32'h0, word_o}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_word", {32'h0, word_o}, {32'h0, e.w});
            chk("beat_flags", {54'h0, first_o, last_o, op_o}, {54'h0, e.first, e.last, e.op});
          end
        end
        hold_prev = word_valid_o && !word_ready_i;
        prev_w    = word_o;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int   waited = 0;
    logic acc;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    do begin
      @(negedge clk);
      acc = rx_ready_o;
      @(posedge clk);
      #1;
      if (!acc) begin
        stall_cnt++;
        waited++;
      end
    end while (!acc && waited < 200);
    if (!acc) chk("byte_accept_timeout", 64'h0, 64'h1);
    rx_valid_i = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    beat_t e;
    for (int k = 0; k < v.nexp; k++) begin
      e.w     = v.w[k];
      e.first = (k == 0);
      e.last  = (k == v.nexp - 1);
      e.op    = v.raw[8*(v.n-1) +: 8];
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pkt(input vec_t v);
    for (int i = 0; i < v.n; i++) send_byte(v.raw[8*(v.n-1-i) +: 8]);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("beats_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    err_seen = 0;
    push_exp(v);
    send_pkt(v);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_err_pulses"}, err_seen, {31'h0, v.err});
  endtask

  initial begin
    vec_t b2b;
    int   t, c0;

    tbl[0]  = mk(12, 128'hAD000C00_01000000_02000000, 2, {32'h0, 32'h0, 32'h2, 32'h1}, 1'b0);
    tbl[1]  = mk(7,  128'hEC000700_414243, 3, {32'h0, 32'h43, 32'h42, 32'h41}, 1'b0);
    tbl[2]  = mk(8,  128'h88000800_78563412, 1, {96'h0, 32'h12345678}, 1'b0);
    tbl[3]  = mk(4,  128'hAD000200, 0, '0, CHK);
    tbl[4]  = mk(4,  128'hD0000400, 0, '0, CHK);
    tbl[5]  = mk(4,  128'hEC000400, 0, '0, 1'b0);
    tbl[6]  = CHK ? mk(10, 128'hAD000A00_11223344_5566, 0, '0, 1'b1)
                  : mk(10, 128'hAD000A00_11223344_5566, 1, {96'h0, 32'h44332211}, 1'b0);
    tbl[7]  = mk(6,  128'h55000600_AABB, 0, '0, CHK);
    tbl[8]  = mk(8,  128'hAD000800_05000000, 1, {96'h0, 32'h5}, 1'b0);
    tbl[9]  = CHK ? mk(8, 128'h55000800_01020304, 0, '0, 1'b1)
                  : mk(8, 128'h55000800_01020304, 1, {96'h0, 32'h04030201}, 1'b0);
    tbl[10] = mk(5,  128'hEC000500_FF, 1, {96'h0, 32'hFF}, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", {58'h0, rx_ready_o, word_valid_o, first_o, last_o, err_o, 1'b0},
        {58'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_data", {24'h0, op_o, word_o}, 64'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: ALU stalls 5 cycles once the first beat is up.
    word_ready_i = 1'b0;
    stall_cnt    = 0;
    fork
      run_vec(tbl[0], "hold");
      begin
        t = 0;
        while (!word_valid_o && t < 100) begin
          @(posedge clk);
          t++;
        end
        repeat (5) @(posedge clk);
        #1;
        word_ready_i = 1'b1;
      end
    join
    chk("hold_rx_ready_dropped", {63'h0, stall_cnt > 0}, 64'h1);

    // Reset in the middle of an ADD payload.
    for (int i = 0; i < 6; i++) send_byte(tbl[0].raw[8*(11-i) +: 8]);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ctrl", {59'h0, rx_ready_o, word_valid_o, first_o, last_o, err_o},
        {59'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("midrst_op", {56'h0, op_o}, 64'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    run_vec(tbl[0], "post_rst");

    // Back-to-back packets at full rate.
    stall_cnt = 0;
    b2b = tbl[8];
    for (int p = 0; p < 3; p++) push_exp(b2b);
    c0 = cyc;
    for (int p = 0; p < 3; p++) send_pkt(b2b);
    chk("b2b_stalls", stall_cnt, 0);
    chk("b2b_cycles", cyc - c0, 24);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

endmodule
